// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential shift-add multiplier with one-hot control and signed mode
module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   signed_mode,
  input  logic [WIDTH-1:0]       multiplicand,
  input  logic [WIDTH-1:0]       multiplier,
  output logic                   busy,
  output logic                   done,
  output logic [2*WIDTH-1:0]     product,
  output logic [4:0]             state
);

  localparam logic [4:0] S_IDLE  = 5'b00001;
  localparam logic [4:0] S_TEST  = 5'b00010;
  localparam logic [4:0] S_ADD   = 5'b00100;
  localparam logic [4:0] S_SHIFT = 5'b01000;
  localparam logic [4:0] S_DONE  = 5'b10000;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] COUNT_LAST = CW'(1);

  logic [4:0]           state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH:0]       p_q, p_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [2*WIDTH-1:0]   shifted;

  // Operand magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1) read as unsigned.
  always_comb begin
    abs_a   = (signed_mode && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
    abs_b   = (signed_mode && multiplier[WIDTH-1])   ? -multiplier   : multiplier;
    // Low 2*WIDTH bits of {P,Q} after one right shift; the new P[WIDTH] is always 0.
    shifted = {p_q, q_q[WIDTH-1:1]};
  end

  // Next-state and datapath control; unknown state encodings fall back to IDLE.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    p_d       = p_q;
    q_d       = q_q;
    count_d   = count_q;
    neg_d     = neg_q;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = abs_a;
          q_d     = abs_b;
          p_d     = '0;
          count_d = COUNT_INIT;
          neg_d   = signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
          state_d = S_TEST;
        end
      end
      S_TEST: begin
        state_d = q_q[0] ? S_ADD : S_SHIFT;
      end
      S_ADD: begin
        p_d     = p_q + {1'b0, a_q};
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        p_d     = {1'b0, p_q[WIDTH:1]};
        q_d     = {p_q[0], q_q[WIDTH-1:1]};
        count_d = count_q - 1'b1;
        if (count_q == COUNT_LAST) begin
          product_d = neg_q ? -shifted : shifted;
          state_d   = S_DONE;
        end else begin
          state_d = S_TEST;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      p_q       <= '0;
      q_q       <= '0;
      count_q   <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      p_q       <= p_d;
      q_q       <= q_d;
      count_q   <= count_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign product = product_q;
  assign state   = state_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - directed self-checking bench for shift_add_multiplier
module tb_shift_add_multiplier;

  logic        clk;
  logic        reset;
  logic        start;
  logic        signed_mode;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic [4:0]  state;

  int passed = 0;
  int total  = 0;

  shift_add_multiplier #(.WIDTH(8)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .signed_mode(signed_mode),
    .multiplicand(multiplicand),
    .multiplier(multiplier),
    .busy(busy),
    .done(done),
    .product(product),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts edges after the start edge until done is seen at a negedge; -1 on timeout.
  task automatic wait_done(output int cycles, output bit saw_add);
    cycles  = -1;
    saw_add = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (state == 5'b00100) saw_add = 1'b1;
      if (done) begin
        cycles = c;
        break;
      end
    end
  endtask

  // Drive one operation, check latency and product, then the return to IDLE.
  task automatic run_op(input string tag, input logic sm, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp_prod, input int exp_lat);
    int  cyc;
    bit  sa;
    start        = 1'b1;
    signed_mode  = sm;
    multiplicand = a;
    multiplier   = b;
    @(posedge clk);
    @(negedge clk);
    start        = 1'b0;
    multiplicand = 8'hA5;
    multiplier   = 8'h5A;
    signed_mode  = ~sm;
    check({tag, "_busy"}, {31'b0, busy}, 32'd1);
    wait_done(cyc, sa);
    check({tag, "_lat"}, cyc, exp_lat);
    check({tag, "_prod"}, {16'b0, product}, {16'b0, exp_prod});
    @(posedge clk);
    @(negedge clk);
    check({tag, "_idle"}, {27'b0, state}, 32'h01);
    check({tag, "_hold"}, {16'b0, product}, {16'b0, exp_prod});
  endtask

  initial begin
    int  cyc;
    bit  sa;
    bit  seen_done;
    reset        = 1'b1;
    start        = 1'b0;
    signed_mode  = 1'b0;
    multiplicand = 8'h00;
    multiplier   = 8'h00;

    @(negedge clk);
    check("rst_state", {27'b0, state}, 32'h01);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_prod", {16'b0, product}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Unsigned basic, then asynchronous reset clearing a held product.
    run_op("u13x11", 1'b0, 8'd13, 8'd11, 16'h008F, 19);
    reset = 1'b1;
    #1;
    check("async_rst_prod", {16'b0, product}, 32'h0);
    check("async_rst_state", {27'b0, state}, 32'h01);
    check("async_rst_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Unsigned corners.
    run_op("u255x255", 1'b0, 8'd255, 8'd255, 16'hFE01, 24);
    start        = 1'b1;
    signed_mode  = 1'b0;
    multiplicand = 8'd200;
    multiplier   = 8'd0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, sa);
    check("u200x0_lat", cyc, 32'd16);
    check("u200x0_prod", {16'b0, product}, 32'h0);
    check("u200x0_noadd", {31'b0, sa}, 32'd0);
    @(posedge clk);
    @(negedge clk);

    // Signed corners.
    run_op("s_m7x5", 1'b1, 8'hF9, 8'd5, 16'hFFDD, 18);
    run_op("s_m128xm128", 1'b1, 8'h80, 8'h80, 16'h4000, 17);
    run_op("s_m128x127", 1'b1, 8'h80, 8'h7F, 16'hC080, 23);

    // Handshake: start held high across two operations.
    start        = 1'b1;
    signed_mode  = 1'b0;
    multiplicand = 8'd3;
    multiplier   = 8'd4;
    @(posedge clk);
    @(negedge clk);
    multiplicand = 8'd6;
    multiplier   = 8'd2;
    wait_done(cyc, sa);
    check("hs1_lat", cyc, 32'd17);
    check("hs1_prod", {16'b0, product}, 32'd12);
    @(posedge clk);
    @(negedge clk);
    check("hs_idle_gap", {27'b0, state}, 32'h01);
    @(posedge clk);
    @(negedge clk);
    check("hs2_accept", {27'b0, state}, 32'h02);
    start = 1'b0;
    wait_done(cyc, sa);
    check("hs2_lat", cyc, 32'd17);
    check("hs2_prod", {16'b0, product}, 32'd12);
    @(posedge clk);
    @(negedge clk);

    // Reset while in ADD: immediate IDLE, product cleared, no done pulse.
    start        = 1'b1;
    multiplicand = 8'd100;
    multiplier   = 8'd255;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc   = -1;
    for (int c = 0; c < 10; c++) begin
      if (state == 5'b00100) begin
        cyc = c;
        break;
      end
      @(negedge clk);
    end
    check("mid_reach_add", {31'b0, (cyc >= 0)}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_state", {27'b0, state}, 32'h01);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_prod", {16'b0, product}, 32'h0);
    seen_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("mid_no_done", {31'b0, seen_done}, 32'd0);
    run_op("u3x3", 1'b0, 8'd3, 8'd3, 16'd9, 18);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
